// File: rtl/glb_stream_arbiter.sv
// rtl/glb_stream_arbiter.sv - round-robin arbiter sharing one GLB stream write channel
//
// Grants one source for a whole length-prefixed stream (one or two segments),
// then rotates round-robin. Datapath is a zero-latency combinational mux of the
// granted source; one IDLE arbitration bubble separates consecutive streams.
//
// Optional feature macro: GLB_ARB_STATS_EN adds stream_cnt, one saturating
// 16-bit completed-stream counter per port.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of arbitration state (highest priority)
//   seg_mode     1: stream = 2 segments, 0: stream = 1 segment (sampled on grant)
//   in_data      packed source data, port i at [i*DATA_W +: DATA_W]
//   in_valid     per-source valid
//   in_ready     per-source ready (only the granted port can be high)
//   out_data     data to the GLB
//   out_valid    valid to the GLB
//   out_ready    ready from the GLB
//   grant        one-hot current owner, 0 when idle
//   stream_done  pulse coincident with the last beat of a stream
//   stream_cnt   (GLB_ARB_STATS_EN only) per-port completed-stream counters

module glb_stream_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 17,
    parameter int LEN_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          seg_mode,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          stream_done
`ifdef GLB_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]       stream_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    state_e               state_q,    state_d;
    logic [NUM_PORTS-1:0] grant_q,    grant_d;
    logic [PTR_W-1:0]     owner_q,    owner_d;
    logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [LEN_W-1:0]     len_cnt_q,  len_cnt_d;
    logic [1:0]           seg_left_q, seg_left_d;

    logic                 beat;
    logic                 seg_end;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     rr_next;
    logic [LEN_W-1:0]     hdr_len;
    int                   cand;

    // ------------------------------------------------------------------
    // Datapath: grant_q is non-zero only in HDR/BODY, so selecting on it
    // alone gives out_valid=0 / out_data=0 while idle.
    // ------------------------------------------------------------------
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                out_data  = in_data[i*DATA_W +: DATA_W];
                out_valid = in_valid[i];
            end
        end
        in_ready = grant_q & {NUM_PORTS{out_ready}};
    end

    assign beat    = out_valid & out_ready;
    assign hdr_len = out_data[LEN_W-1:0];
    assign grant   = grant_q;

    // ------------------------------------------------------------------
    // Round-robin winner: first valid port at or after rr_ptr, with wrap.
    // Scanning offsets downward lets the smallest offset overwrite last.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign rr_next = (owner_q == PTR_W'(NUM_PORTS - 1)) ? '0 : owner_q + PTR_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        len_cnt_d   = len_cnt_q;
        seg_left_d  = seg_left_q;
        seg_end     = 1'b0;
        stream_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
                    owner_d    = win_idx;
                    seg_left_d = seg_mode ? 2'd2 : 2'd1;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (beat) begin
                    // A zero-length header is a complete segment by itself;
                    // this keeps BODY from ever starting with len_cnt=0.
                    if (hdr_len == '0) begin
                        seg_end = 1'b1;
                    end else begin
                        len_cnt_d = hdr_len;
                        state_d   = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (beat) begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                    if (len_cnt_q == LEN_W'(1)) begin
                        seg_end = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (seg_end) begin
            seg_left_d = seg_left_q - 2'd1;
            if (seg_left_q == 2'd1) begin
                stream_done = 1'b1;
                rr_ptr_d    = rr_next;
                grant_d     = '0;
                state_d     = ST_IDLE;
            end else begin
                state_d = ST_HDR;
            end
        end

        // Flush abandons any partial stream without reporting completion.
        if (flush) begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            owner_d     = '0;
            rr_ptr_d    = '0;
            len_cnt_d   = '0;
            seg_left_d  = '0;
            stream_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            len_cnt_q  <= '0;
            seg_left_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            len_cnt_q  <= len_cnt_d;
            seg_left_q <= seg_left_d;
        end
    end

`ifdef GLB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-port saturating completed-stream counters
    // ------------------------------------------------------------------
    logic [15:0] cnt_q [NUM_PORTS];
    logic [15:0] cnt_d [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (stream_done && (owner_q == PTR_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stream_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            stream_cnt[i*16 +: 16] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// tb/tb_glb_stream_arbiter.sv - self-checking bench for glb_stream_arbiter

module tb_glb_stream_arbiter;

    localparam int NP = 3;
    localparam int DW = 17;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               seg_mode;
    logic [NP*DW-1:0]   in_data;
    logic [NP-1:0]      in_valid;
    logic [NP-1:0]      in_ready;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic [NP-1:0]      grant;
    logic               stream_done;
`ifdef GLB_ARB_STATS_EN
    logic [NP*16-1:0]   stream_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    glb_stream_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .seg_mode   (seg_mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant      (grant),
        .stream_done(stream_done)
`ifdef GLB_ARB_STATS_EN
        ,
        .stream_cnt (stream_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 2 time units after the next rising edge; inputs are driven
    // there and outputs sampled one unit later, far from either edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] w);
        in_data[p*DW +: DW] = w;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        seg_mode  = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        seg_mode  = 1'b0;
        in_valid  = '1;
        in_data   = {$urandom, $urandom};
        out_ready = 1'b1;
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 3'b000) $display("FAIL reset_in_ready: got %b want 000", in_ready); else pass_cnt++;
        total_cnt++; if (out_data !== 17'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (stream_done !== 1'b0) $display("FAIL reset_stream_done: got %b want 0", stream_done); else pass_cnt++;
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        total_cnt++; if (grant !== 3'b001) $display("FAIL reset_first_grant: got %b want 001", grant); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL reset_async_grant: got %b want 000", grant); else pass_cnt++;
        total_cnt++; if (in_ready !== 3'b000) $display("FAIL reset_async_in_ready: got %b want 000", in_ready); else pass_cnt++;
        in_valid = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] w [4];
        w[0] = 17'd3;
        for (int i = 1; i < 4; i++) w[i] = DW'($urandom);
        do_reset();
        out_ready = 1'b1;
        in_valid  = 3'b001;
        set_data(0, w[0]);
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL single_bubble_grant: got %b want 000", grant); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_bubble_valid: got %b want 0", out_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_data(0, w[i]);
            #1;
            total_cnt++; if (grant !== 3'b001) $display("FAIL single_grant[%0d]: got %b want 001", i, grant); else pass_cnt++;
            total_cnt++; if (out_data !== w[i]) $display("FAIL single_data[%0d]: got %h want %h", i, out_data, w[i]); else pass_cnt++;
            total_cnt++; if (in_ready !== 3'b001) $display("FAIL single_in_ready[%0d]: got %b want 001", i, in_ready); else pass_cnt++;
            total_cnt++; if (stream_done !== (i == 3)) $display("FAIL single_done[%0d]: got %b want %b", i, stream_done, (i == 3)); else pass_cnt++;
        end
        cyc();
        in_valid = 3'b000;
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL single_release: got %b want 000", grant); else pass_cnt++;
    endtask

    task automatic test_rr();
        int            pos [2];
        logic [DW-1:0] xv [2];
        logic [NP-1:0] prev_g;
        logic [NP-1:0] exp_g;
        int            idle_run;
        int            got;
        do_reset();
        pos[0] = 0; pos[1] = 0;
        xv[0] = DW'($urandom); xv[1] = DW'($urandom);
        prev_g = '0; exp_g = 3'b001; idle_run = 0; got = 0;
        out_ready = 1'b1;
        in_valid  = 3'b011;
        for (int n = 0; n < 40 && got < 4; n++) begin
            for (int p = 0; p < 2; p++) set_data(p, (pos[p] == 0) ? 17'd1 : xv[p]);
            #1;
            if (grant !== 3'b000 && grant !== prev_g) begin
                total_cnt++; if (grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b want %b", got, grant, exp_g); else pass_cnt++;
                total_cnt++; if (idle_run !== 1) $display("FAIL rr_bubble[%0d]: got %0d idle cycles want 1", got, idle_run); else pass_cnt++;
                exp_g = (exp_g == 3'b001) ? 3'b010 : 3'b001;
                idle_run = 0;
                got++;
            end else if (grant === 3'b000) begin
                idle_run++;
            end
            prev_g = grant;
            for (int p = 0; p < 2; p++) if (in_valid[p] && in_ready[p]) pos[p] = 1 - pos[p];
            cyc();
        end
        total_cnt++; if (got !== 4) $display("FAIL rr_count: got %0d grants want 4", got); else pass_cnt++;
        in_valid = '0;
    endtask

    task automatic test_seg();
        logic [DW-1:0] w [4];
        w[0] = 17'd2;
        w[1] = DW'($urandom);
        w[2] = DW'($urandom);
        w[3] = {1'b1, 16'd0};
        do_reset();
        seg_mode  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 3'b010;
        set_data(1, w[0]);
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL seg_bubble: got %b want 000", grant); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            seg_mode = 1'b0;
            set_data(1, w[i]);
            #1;
            total_cnt++; if (grant !== 3'b010) $display("FAIL seg_grant[%0d]: got %b want 010", i, grant); else pass_cnt++;
            total_cnt++; if (out_data !== w[i]) $display("FAIL seg_data[%0d]: got %h want %h", i, out_data, w[i]); else pass_cnt++;
            total_cnt++; if (stream_done !== (i == 3)) $display("FAIL seg_done[%0d]: got %b want %b", i, stream_done, (i == 3)); else pass_cnt++;
        end
        cyc();
        in_valid = '0;
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL seg_release: got %b want 000", grant); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [6];
        int            idx;
        logic          v0;
        w[0] = 17'd5;
        for (int i = 1; i < 6; i++) w[i] = DW'($urandom);
        do_reset();
        idx = 0;
        for (int n = 0; n < 60 && idx < 6; n++) begin
            out_ready = (n % 2 == 0);
            v0 = (idx == 0) || ($urandom % 3 != 0);
            in_valid = {1'b0, 1'b1, v0};
            set_data(0, w[idx]);
            set_data(1, 17'd0);
            #1;
            if (n == 0) begin
                total_cnt++; if (grant !== 3'b000) $display("FAIL bp_bubble: got %b want 000", grant); else pass_cnt++;
            end else begin
                total_cnt++; if (grant !== 3'b001) $display("FAIL bp_grant[%0d]: got %b want 001", n, grant); else pass_cnt++;
                total_cnt++; if (in_ready !== {2'b00, out_ready}) $display("FAIL bp_in_ready[%0d]: got %b want %b", n, in_ready, {2'b00, out_ready}); else pass_cnt++;
                total_cnt++; if (out_valid !== v0) $display("FAIL bp_out_valid[%0d]: got %b want %b", n, out_valid, v0); else pass_cnt++;
            end
            if (out_valid && out_ready) begin
                total_cnt++; if (out_data !== w[idx]) $display("FAIL bp_data[%0d]: got %h want %h", idx, out_data, w[idx]); else pass_cnt++;
                total_cnt++; if (stream_done !== (idx == 5)) $display("FAIL bp_done[%0d]: got %b want %b", idx, stream_done, (idx == 5)); else pass_cnt++;
                idx++;
            end else begin
                total_cnt++; if (stream_done !== 1'b0) $display("FAIL bp_done_idle[%0d]: got %b want 0", n, stream_done); else pass_cnt++;
            end
            cyc();
        end
        total_cnt++; if (idx !== 6) $display("FAIL bp_beats: got %0d want 6", idx); else pass_cnt++;
        in_valid = 3'b010;
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL bp_after_bubble: got %b want 000", grant); else pass_cnt++;
        cyc();
        #1;
        total_cnt++; if (grant !== 3'b010) $display("FAIL bp_next_owner: got %b want 010", grant); else pass_cnt++;
        in_valid = '0;
    endtask

    task automatic test_flush();
        logic [DW-1:0] w [5];
        w[0] = 17'd4;
        for (int i = 1; i < 5; i++) w[i] = DW'($urandom);
        do_reset();
        out_ready = 1'b1;
        // Port 0 completes a one-word stream so the pointer moves to port 1.
        in_valid = 3'b001;
        set_data(0, 17'd0);
        cyc();
        #1;
        total_cnt++; if (stream_done !== 1'b1) $display("FAIL flush_pre_done: got %b want 1", stream_done); else pass_cnt++;
        cyc();
        in_valid = 3'b010;
        set_data(1, w[0]);
        cyc();
        set_data(1, w[0]);
        #1;
        total_cnt++; if (grant !== 3'b010) $display("FAIL flush_owner: got %b want 010", grant); else pass_cnt++;
        cyc();
        set_data(1, w[1]);
        #1;
        total_cnt++; if (out_data !== w[1]) $display("FAIL flush_beat2: got %h want %h", out_data, w[1]); else pass_cnt++;
        cyc();
        flush = 1'b1;
        set_data(1, w[2]);
        #1;
        total_cnt++; if (stream_done !== 1'b0) $display("FAIL flush_no_done: got %b want 0", stream_done); else pass_cnt++;
        cyc();
        flush = 1'b0;
        in_valid = 3'b011;
        set_data(0, 17'd0);
        #1;
        total_cnt++; if (grant !== 3'b000) $display("FAIL flush_grant: got %b want 000", grant); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (stream_done !== 1'b0) $display("FAIL flush_done_after: got %b want 0", stream_done); else pass_cnt++;
        cyc();
        #1;
        total_cnt++; if (grant !== 3'b001) $display("FAIL flush_rr_restart: got %b want 001", grant); else pass_cnt++;
        in_valid = '0;
    endtask

    // Reference model: per-port queues of whole streams. Arbitration picks
    // the first port at/after the model pointer holding a pending stream;
    // sources only insert valid gaps inside a stream that has started.
    task automatic test_random(input logic smode);
        logic [DW-1:0] wq   [NP][$];
        int            slen [NP][$];
        int            started [NP];
        int            act;
        int            rr_m;
        int            ns;
        int            segs;
        int            len;
        int            words;
        int            n;
        logic          active_v;
        logic          picked_now;
        logic          pending;
        logic [NP-1:0] exp_oh;
        do_reset();
        seg_mode = smode;
        segs = smode ? 2 : 1;
        for (int p = 0; p < NP; p++) begin
            started[p] = 0;
            ns = $urandom_range(0, 3);
            for (int s = 0; s < ns; s++) begin
                words = 0;
                for (int g = 0; g < segs; g++) begin
                    len = $urandom_range(0, 4);
                    wq[p].push_back({1'($urandom), 16'(len)});
                    words++;
                    for (int j = 0; j < len; j++) begin
                        wq[p].push_back(DW'($urandom));
                        words++;
                    end
                end
                slen[p].push_back(words);
            end
        end
        act = 0; rr_m = 0; active_v = 1'b0; n = 0;
        pending = 1'b1;
        while ((pending || active_v) && n < 3000) begin
            out_ready = ($urandom % 4 != 0);
            for (int p = 0; p < NP; p++) begin
                if (wq[p].size() > 0) begin
                    in_valid[p] = (started[p] != 0) ? ($urandom % 3 != 0) : 1'b1;
                    set_data(p, wq[p][0]);
                end else begin
                    in_valid[p] = 1'b0;
                    set_data(p, DW'($urandom));
                end
            end
            #1;
            picked_now = 1'b0;
            if (!active_v) begin
                for (int k = 0; k < NP && !active_v; k++) begin
                    if (wq[(rr_m + k) % NP].size() > 0) begin
                        act = (rr_m + k) % NP;
                        active_v = 1'b1;
                        picked_now = 1'b1;
                    end
                end
            end
            exp_oh = (active_v && !picked_now) ? (3'b001 << act) : 3'b000;
            total_cnt++; if (grant !== exp_oh) $display("FAIL rand_grant[%0d]: got %b want %b", n, grant, exp_oh); else pass_cnt++;
            total_cnt++; if (out_valid !== ((exp_oh & in_valid) != 0)) $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, ((exp_oh & in_valid) != 0)); else pass_cnt++;
            if (out_valid && out_ready && exp_oh != 3'b000) begin
                total_cnt++; if (out_data !== wq[act][0]) $display("FAIL rand_data[%0d]: got %h want %h", n, out_data, wq[act][0]); else pass_cnt++;
                total_cnt++; if (in_ready !== exp_oh) $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, exp_oh); else pass_cnt++;
                total_cnt++; if (stream_done !== (slen[act][0] == 1)) $display("FAIL rand_done[%0d]: got %b want %b", n, stream_done, (slen[act][0] == 1)); else pass_cnt++;
                void'(wq[act].pop_front());
                slen[act][0] = slen[act][0] - 1;
                started[act] = 1;
                if (slen[act][0] == 0) begin
                    void'(slen[act].pop_front());
                    started[act] = 0;
                    active_v = 1'b0;
                    rr_m = (act + 1) % NP;
                end
            end else begin
                total_cnt++; if (stream_done !== 1'b0) $display("FAIL rand_done_idle[%0d]: got %b want 0", n, stream_done); else pass_cnt++;
            end
            pending = 1'b0;
            for (int p = 0; p < NP; p++) if (wq[p].size() > 0) pending = 1'b1;
            cyc();
            n++;
        end
        total_cnt++; if (pending || active_v) $display("FAIL rand_drain: got pending=%b active=%b want both 0", pending, active_v); else pass_cnt++;
        in_valid = '0;
    endtask

`ifdef GLB_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b1;
        #1;
        total_cnt++; if (stream_cnt !== 48'd0) $display("FAIL stats_reset: got %h want 0", stream_cnt); else pass_cnt++;
        set_data(2, 17'd0);
        set_data(0, 17'd0);
        in_valid = 3'b100;
        for (int k = 0; k < 6; k++) cyc();
        in_valid = 3'b001;
        cyc();
        cyc();
        in_valid = 3'b000;
        cyc();
        #1;
        total_cnt++; if (stream_cnt !== {16'd3, 16'd0, 16'd1}) $display("FAIL stats_count: got %h want %h", stream_cnt, {16'd3, 16'd0, 16'd1}); else pass_cnt++;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        total_cnt++; if (stream_cnt !== 48'd0) $display("FAIL stats_flush: got %h want 0", stream_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_seg();
        test_backpressure();
        test_flush();
        test_random(1'b0);
        test_random(1'b1);
`ifdef GLB_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/glb_stream_arbiter.md
Name: glb_stream_arbiter

Overview:
- Shares one GLB stream write channel (17-bit ready/valid) between NUM_PORTS stream sources.
- Each source emits length-prefixed sparse streams; the arbiter grants one source for a whole stream, then rotates round-robin.
- Sits between the per-tile stream sources and the single GLB write port. Tracks segment boundaries so streams are never interleaved.

Parameters:
- NUM_PORTS, 2, number of requesters (legal values 2..4).
- DATA_W, 17, stream word width.
- LEN_W, 16, width of the length field; the length is taken from data[LEN_W-1:0] of a header word.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of arbitration state.
- seg_mode  input  1  when 1, a stream is 2 segments; when 0, a stream is 1 segment. Sampled on grant.
- in_data  input  NUM_PORTS*DATA_W  packed source data; port i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_PORTS  per-source valid.
- in_ready  output  NUM_PORTS  per-source ready.
- out_data  output  DATA_W  data to the GLB.
- out_valid  output  1  valid to the GLB.
- out_ready  input  1  ready from the GLB.
- grant  output  NUM_PORTS  one-hot current owner; 0 when idle.
- stream_done  output  1  one-cycle pulse on the last beat of a stream.

Behaviour:
- Reset (async, rst_n=0) sets state=IDLE, grant=0, rr_ptr=0, len_cnt=0, seg_left=0, stream_done=0. Outputs are then out_valid=0, in_ready=0, out_data=0.
- flush=1 is synchronous and has the highest priority. It applies the same values as reset on the next edge. A partially sent stream is abandoned and no stream_done is generated.
- Datapath is a combinational mux of the granted port:
  - out_data = in_data[g]; out_valid = in_valid[g] in states HDR and BODY.
  - in_ready[g] = out_ready in states HDR and BODY; all other in_ready bits are 0.
  - In IDLE: out_valid=0, out_data=0.
  - Zero added latency per beat.
- Beat = out_valid & out_ready.
- FSM states: IDLE, HDR, BODY.
- IDLE:
  - If any in_valid is high, the winner is the first valid port at or after rr_ptr, searching upward with wrap.
  - Register grant=onehot(winner), seg_left = seg_mode ? 2 : 1, then go to HDR.
  - No beat is passed in the IDLE cycle, so there is one arbitration bubble per stream.
- HDR: on a beat, L = data[LEN_W-1:0].
  - If L==0, the segment ends on this beat.
  - Otherwise len_cnt=L and go to BODY.
- BODY: each beat decrements len_cnt. A beat with len_cnt==1 ends the segment.
- Segment end:
  - seg_left decrements.
  - If the result is 0: stream_done=1 for that cycle, rr_ptr = (winner+1) mod NUM_PORTS, grant=0, go to IDLE.
  - Otherwise go to HDR.
- seg_mode changes during a grant are ignored until the next IDLE.
- in_valid dropping mid-stream holds the FSM (no timeout); grant stays locked.
- Arithmetic: len_cnt is LEN_W bits. The maximum segment is 2^LEN_W-1 body words plus 1 header word. No wrap occurs because BODY is never entered with L=0.
- in_valid of non-granted ports has no effect until IDLE.

Optional Feature:
- Macro GLB_ARB_STATS_EN.
- When defined:
  - Adds output stream_cnt (NUM_PORTS*16 bits).
  - One saturating 16-bit counter per port, incremented on that port's stream_done.
  - Cleared by reset and by flush; saturates at 16'hFFFF.
- When undefined: the port and counters are absent, with no other behaviour change.

Test Plan:
- Reset, then port0 sends a non-seg stream [3,A,B,C] with out_ready=1. Expect grant=01 one cycle after in_valid, 4 beats with out_data=3,A,B,C, stream_done on beat C, then grant=00.
- Ports 0 and 1 are both always valid, each sending [1,X], seg_mode=0. Expect grant sequence 01,10,01,10 with one idle cycle between streams.
- seg_mode=1, port1 sends [2,A,B,0]. Expect 4 beats, stream_done only on the 4th beat (the L=0 header), and no stream_done after beat B.
- Port0 stream [5,...] with out_ready toggled 1,0,1,0 and in_valid gaps. Expect exactly 6 beats passed in order, in_ready[0] mirroring out_ready, and port1 never granted mid-stream.
- Flush asserted after the 2nd beat of [4,A,B,C,D] on port1. Next cycle: grant=0, state IDLE, rr_ptr=0, no stream_done. Port0 and port1 then both valid: expect port0 granted first.
- GLB_ARB_STATS_EN: 3 streams on port2 and 1 stream on port0 (NUM_PORTS=3). Expect stream_cnt = {3,0,1}, and all zeros after flush.
